// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions: NOP encoding, opcodes, fetch FSM states
// and the default reset PC.
package riscv_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order instruction buffer with push/pop/flush; a push while
// full is accepted when a pop frees the slot in the same cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage is data only; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, buffer toward
// the decoder, redirect squashing. FETCH_PERF_CNT_EN adds saturating counters.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + 32;

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [ADDR_W-1:0] req_pc;
    logic              drop, drop_d;
    logic              outstanding;
    logic              push, pop, flush;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  head;
    logic [31:0]       hold_inst;
    logic [ADDR_W-1:0] hold_pc;
    logic [ADDR_W-1:0] redirect_tgt;
    logic [1:0]        unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = redirect_pc[1:0];
    assign imem_addr            = pc;

    // outstanding: a granted request whose rvalid is still to come after this edge.
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        drop_d      = drop;
        push        = 1'b0;
        imem_req    = 1'b0;
        outstanding = 1'b0;
        flush       = redirect_valid;
        pop         = !fifo_empty && inst_ready;
        case (state)
            IDLE: begin
                // After a reset mid-WAIT the stale response must land before refetching.
                outstanding = drop && !imem_rvalid;
                if (drop) begin
                    if (imem_rvalid) drop_d = 1'b0;
                end else if (!fifo_full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    pc_d        = pc + ADDR_W'(4);
                    state_d     = WAIT;
                    outstanding = 1'b1;
                end
            end
            WAIT: begin
                outstanding = !imem_rvalid;
                if (imem_rvalid) begin
                    push   = !drop;
                    drop_d = 1'b0;
                    if (int'(fifo_count) + int'(!drop) - int'(pop) < FIFO_DEPTH)
                        state_d = REQ;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            pc_d    = redirect_tgt;
            push    = 1'b0;
            pop     = 1'b0;
            drop_d  = outstanding;
            state_d = outstanding ? WAIT : REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            drop  <= outstanding;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            drop  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state == REQ && imem_gnt) req_pc <= pc;
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({req_pc, imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Last presented entry is kept so inst/inst_pc stay defined while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_inst <= NOP_INST;
            hold_pc   <= RESET_PC;
        end else if (!fifo_empty) begin
            hold_inst <= head[31:0];
            hold_pc   <= head[ENT_W-1:32];
        end
    end

    assign inst_valid = !fifo_empty;
    assign inst       = fifo_empty ? hold_inst : head[31:0];
    assign inst_pc    = fifo_empty ? hold_pc : head[ENT_W-1:32];

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push)        perf_fetched <= sat_inc(perf_fetched);
            if (!inst_valid) perf_stall   <= sat_inc(perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle table for start-up/back-pressure plus
// hand sequences for redirect, grant delay, reset mid-fetch and PC wrap.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    inst_fetch #(
        .ADDR_W     (32),
        .FIFO_DEPTH (2),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    int          gnt_delay = 0;
    int          rv_lat    = 1;
    int          g_cnt     = 0;
    int          rv_cnt    = 0;
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[15:0], 16'h0013};
    endfunction

    // Memory model: grant after gnt_delay waiting cycles, rvalid rv_lat cycles after grant.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (pend) begin
                if (rv_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                    pend        = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            if (imem_req === 1'b1) begin
                if (g_cnt >= gnt_delay) begin
                    imem_gnt  = 1'b1;
                    pend      = 1'b1;
                    pend_addr = imem_addr;
                    rv_cnt    = rv_lat - 1;
                    g_cnt     = 0;
                end else begin
                    g_cnt++;
                end
            end else begin
                g_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b1;
        step();
        n = 0;
        while ((pend || imem_rvalid) && n < 20) begin
            step();
            n++;
        end
        chk("reset_mem_idle", 32'(pend), 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (inst_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk({name, "_arrives"}, 32'(inst_valid), 32'd1);
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [20];

    initial begin
        rst            = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        //               rst   ready req   addr          valid inst           pc
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0013, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0013, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 32'h0000_0013, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0050_0093, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 32'h0050_0093, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0004_0013, 32'h4};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0004_0013, 32'h4};
        for (int k = 7; k < 16; k++)
            tbl[k] = '{1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0004_0013, 32'h4};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0008_0013, 32'h8};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0008_0013, 32'h8};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'h0008_0013, 32'h8};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h000C_0013, 32'hC};

        for (int k = 0; k < 20; k++) begin
            rst        = tbl[k].rst;
            inst_ready = tbl[k].ready;
            step();
            chk($sformatf("v%0d_req", k),   32'(imem_req),   32'(tbl[k].req));
            chk($sformatf("v%0d_addr", k),  imem_addr,       tbl[k].addr);
            chk($sformatf("v%0d_valid", k), 32'(inst_valid), 32'(tbl[k].valid));
            chk($sformatf("v%0d_inst", k),  inst,            tbl[k].inst);
            chk($sformatf("v%0d_pc", k),    inst_pc,         tbl[k].pc);
        end

        // Redirect while waiting; stale word arrives one cycle after the redirect.
        gnt_delay  = 0;
        rv_lat     = 2;
        inst_ready = 1'b1;
        do_reset();
        step();
        chk("redir_req0", 32'(imem_req), 32'd1);
        step();
        chk("redir_wait_addr", imem_addr, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        chk("redir_pc", imem_addr, 32'h100);
        chk("redir_req_held", 32'(imem_req), 32'd0);
        step();
        chk("redir_stale_dropped", 32'(inst_valid), 32'd0);
        chk("redir_new_req", 32'(imem_req), 32'd1);
        chk("redir_new_addr", imem_addr, 32'h100);
        wait_valid("redir");
        chk("redir_first_pc", inst_pc, 32'h100);
        chk("redir_first_inst", inst, 32'h0100_0013);

        // Grant held off for three cycles.
        gnt_delay = 3;
        rv_lat    = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("gdly_req%0d", i),  32'(imem_req), 32'd1);
            chk($sformatf("gdly_addr%0d", i), imem_addr,     32'h0);
        end
        step();
        chk("gdly_after_req", 32'(imem_req), 32'd0);
        chk("gdly_after_addr", imem_addr, 32'h4);
        wait_valid("gdly");
        chk("gdly_pc", inst_pc, 32'h0);

        // Reset asserted in WAIT; the pending response comes back after reset.
        gnt_delay = 0;
        rv_lat    = 3;
        do_reset();
        step();
        chk("rstw_req", 32'(imem_req), 32'd1);
        step();
        chk("rstw_wait", 32'(imem_req), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_rst_valid", 32'(inst_valid), 32'd0);
        chk("rstw_rst_inst", inst, 32'h0000_0013);
        chk("rstw_rst_addr", imem_addr, 32'h0);
        step();
        chk("rstw_no_req_pending", 32'(imem_req), 32'd0);
        step();
        chk("rstw_stale_dropped", 32'(inst_valid), 32'd0);
        chk("rstw_no_req_drop", 32'(imem_req), 32'd0);
        step();
        chk("rstw_refetch_req", 32'(imem_req), 32'd1);
        chk("rstw_refetch_addr", imem_addr, 32'h0);
        wait_valid("rstw");
        chk("rstw_pc", inst_pc, 32'h0);
        chk("rstw_inst", inst, 32'h0050_0093);

        // PC wrap from the top of the address space.
        gnt_delay = 5;
        rv_lat    = 1;
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        gnt_delay      = 0;
        chk("wrap_req", 32'(imem_req), 32'd1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr_held", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_next_addr", imem_addr, 32'h0);
        wait_valid("wrap");
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_inst", inst, 32'hFFFC_0013);
        chk("wrap_refetch_addr", imem_addr, 32'h0);

        // Redirect with a full buffer flushes it.
        gnt_delay  = 0;
        rv_lat     = 1;
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("flush_full_valid", 32'(inst_valid), 32'd1);
        chk("flush_full_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("flush_req", 32'(imem_req), 32'd1);
        chk("flush_addr", imem_addr, 32'h200);
        wait_valid("flush");
        chk("flush_pc", inst_pc, 32'h200);
        chk("flush_inst", inst, 32'h0200_0013);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
